tdm_demux_16ch: RTL and testbench
=================================

# tdm_demux_16ch

Receive-side counterpart of the team's 16:1 bit multiplexer. It takes a 1-bit time-division-multiplexed stream, one channel per slot in the order 0..15, and routes each slot's bit to its channel position. A full 16-bit frame is presented on a parallel output with a one-cycle valid pulse. It sits at the far end of a serial link whose transmitter drives `in[sel]` with a rotating `sel`, and restores the 16 parallel channels.

## Interface
- `NUM_CH`, 16, number of channels (slots per frame); fixed at 16 for this revision.
- `SEL_W`, 4, slot index width, equal to log2(NUM_CH).

One clock; reset is asynchronous and active-high.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous active-high reset.
- `din`  input  1  serial data bit for the current slot.
- `din_valid`  input  1  slot strobe; `din` is sampled only when high.
- `frame_sync`  input  1  marks the slot-0 bit; meaningful only with `din_valid`.
- `dout`  output  NUM_CH  last complete frame; bit i = channel i.
- `dout_valid`  output  1  one-cycle pulse when `dout` updates.
- `slot`  output  SEL_W  index the next accepted bit will be written to.
- `locked`  output  1  high while the frame alignment state is LOCKED.
- `sync_err`  output  1  one-cycle pulse on an alignment violation.

## Operation
- Reset values: `dout`=16'h0000, `dout_valid`=0, `slot`=0, `locked`=0, `sync_err`=0, state=HUNT, shadow register=0.
- Accepted beat: `din_valid`=1 on a rising edge. With `din_valid`=0, nothing changes and `frame_sync` is ignored.
- HUNT state:
  - Beats without `frame_sync` are discarded.
  - A beat with `frame_sync` writes `shadow[0]`=`din`, sets `slot`=1, and moves to LOCKED.
- LOCKED, beat at `slot`=k with 1≤k≤14 and no `frame_sync`:
  - `shadow[k]`=`din`, then `slot`=k+1.
- LOCKED, beat at `slot`=15 and no `frame_sync`:
  - Next edge: `dout` = {`din`, `shadow[14:0]`} and `dout_valid`=1.
  - `slot` wraps to 0.
- LOCKED, beat at `slot`=0 with `frame_sync`:
  - `shadow[0]`=`din`, then `slot`=1. This is normal frame start.
- LOCKED, beat at `slot`=0 without `frame_sync`:
  - `sync_err` pulses, state goes to HUNT, `slot`=0, and the bit is discarded.
- LOCKED, beat at `slot`≠0 with `frame_sync` (early sync):
  - `sync_err` pulses and the partial frame is discarded without a `dout_valid`.
  - The beat is treated as a new slot 0: `shadow[0]`=`din`, `slot`=1, state stays LOCKED.
- `shadow` bits from an aborted frame are never exposed. `dout` changes only on a completed 16-beat frame.
- `locked` = (state == LOCKED), driven from a register.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). No `dout_valid` is generated for the partial frame.

## Timing
- Every output is registered; there is no combinational path from an input to an output.
- Latency: the slot-15 beat at edge N gives `dout`/`dout_valid` valid after edge N, i.e. visible in cycle N+1. `dout_valid` drops after one cycle unless another frame completes.
- Maximum throughput is one beat per cycle, so one frame every 16 cycles. Back-to-back frames produce a `dout_valid` every 16 cycles with no gap.
- `sync_err` is asserted in the cycle after the offending beat, for exactly one cycle.
- `dout` holds its value between frames; the consumer samples it on `dout_valid`.
- Reset deassertion: the first beat is evaluated at the first rising edge after `rst` falls.

## Structure
- Package `tdm_pkg` contains:
  - constants `NUM_CH`=16 and `SEL_W`=4;
  - state enum {HUNT, LOCKED};
  - the shared transmitter/receiver slot order (slot k = channel k).
- Sub-module `tdm_slot_counter`:
  - SEL_W-bit counter with `inc`, `load0` and `load1` controls plus a `wrap` flag at 15;
  - also reused by the future transmitter.
- Top level contains the FSM, the shadow register and the output registers.

## Test plan
- Reset and lock:
  - Stimulus: reset, then 16 beats starting with `frame_sync` carrying channel pattern 16'hA5C3 (slot k = bit k).
  - Required: `locked`=1 after the first beat; `dout`=16'hA5C3 with a single `dout_valid` pulse one cycle after the 16th beat.
- Back-to-back frames:
  - Stimulus: frames 16'h0001, 16'h8000, 16'hFFFF on continuous `din_valid`.
  - Required: three `dout_valid` pulses spaced 16 cycles apart with the matching `dout` values.
- Gapped strobes:
  - Stimulus: frame 16'h1234 with `din_valid` low on random cycles (≥30% idle).
  - Required: `dout`=16'h1234; `slot` never advances on idle cycles.
- Early sync:
  - Stimulus: `frame_sync` with a beat at `slot`=7, then a full frame 16'h00FF starting at that beat.
  - Required: `sync_err` pulses once, no `dout_valid` for the aborted frame, then `dout`=16'h00FF.
- Missing sync:
  - Stimulus: after a good frame, the next slot-0 beat arrives without `frame_sync`.
  - Required: `sync_err` pulses, `locked`=0, and beats are ignored until the next `frame_sync`.
- Async reset mid-frame:
  - Stimulus: assert `rst` between clock edges at `slot`=9.
  - Required: `slot`=0, `locked`=0 and `dout`=0 immediately, with no `dout_valid`.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link: channel count, slot width, alignment
// states and the slot-to-channel order used by both transmitter and receiver.
package tdm_pkg;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned SEL_W  = 4;

  localparam logic [SEL_W-1:0] FIRST_SLOT = '0;
  localparam logic [SEL_W-1:0] LAST_SLOT  = SEL_W'(NUM_CH - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Slot k carries channel k on both ends of the link.
  function automatic logic [SEL_W-1:0] slot_to_ch(input logic [SEL_W-1:0] s);
    return s;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter shared by the TDM transmitter and receiver.
// load0 has priority over load1, which has priority over inc.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load0,
  input  logic             load1,
  output logic [SEL_W-1:0] count,
  output logic             wrap
);

  logic [SEL_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load0) begin
      r_count <= '0;
    end else if (load1) begin
      r_count <= SEL_W'(1);
    end else if (inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign wrap  = (r_count == LAST_SLOT);

endmodule

// File: rtl/tdm_demux_16ch.sv
// 16-channel TDM receiver: aligns on frame_sync, collects one bit per slot
// into a shadow register and publishes each complete frame with a valid pulse.
module tdm_demux_16ch
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [NUM_CH-1:0] dout,
  output logic              dout_valid,
  output logic [SEL_W-1:0]  slot,
  output logic              locked,
  output logic              sync_err
);

  state_t r_state;
  state_t w_state_nxt;

  // The last slot's bit goes straight into dout, so shadow holds slots 0..14 only.
  logic [NUM_CH-2:0] r_shadow;
  logic [NUM_CH-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_locked;
  logic              r_sync_err;

  logic [SEL_W-1:0]  w_slot;
  logic              w_wrap;
  logic              w_inc;
  logic              w_load0;
  logic              w_load1;
  logic              w_sh_we;
  logic [SEL_W-1:0]  w_sh_idx;
  logic              w_done;
  logic              w_err;

  tdm_slot_counter u_slot_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_inc),
    .load0 (w_load0),
    .load1 (w_load1),
    .count (w_slot),
    .wrap  (w_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_inc       = 1'b0;
    w_load0     = 1'b0;
    w_load1     = 1'b0;
    w_sh_we     = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    if (din_valid) begin
      case (r_state)
        HUNT: begin
          if (frame_sync) begin
            w_sh_we     = 1'b1;
            w_load1     = 1'b1;
            w_state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // Early sync restarts the frame at this beat; partial bits are overwritten.
            w_err   = (w_slot != FIRST_SLOT);
            w_sh_we = 1'b1;
            w_load1 = 1'b1;
          end else if (w_slot == FIRST_SLOT) begin
            w_err       = 1'b1;
            w_load0     = 1'b1;
            w_state_nxt = HUNT;
          end else if (w_wrap) begin
            w_done  = 1'b1;
            w_load0 = 1'b1;
          end else begin
            w_sh_we = 1'b1;
            w_inc   = 1'b1;
          end
        end
        default: begin
          w_state_nxt = HUNT;
        end
      endcase
    end
  end

  assign w_sh_idx = frame_sync ? slot_to_ch(FIRST_SLOT) : slot_to_ch(w_slot);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (w_sh_we) begin
      r_shadow[w_sh_idx] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      if (w_done) begin
        r_dout <= {din, r_shadow};
      end
      r_dout_valid <= w_done;
      r_locked     <= (w_state_nxt == LOCKED);
      r_sync_err   <= w_err;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign slot       = w_slot;
  assign locked     = r_locked;
  assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_tdm_demux_16ch.sv
// Randomised bench for tdm_demux_16ch: a bit-list reference model drives
// per-beat slot/locked/sync_err checks and a frame scoreboard for dout.
module tb_tdm_demux_16ch;
  import tdm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic        din_valid;
  logic        frame_sync;
  logic [15:0] dout;
  logic        dout_valid;
  logic [3:0]  slot;
  logic        locked;
  logic        sync_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  bit          m_bits[$];
  bit          m_locked;
  logic [15:0] exp_q[$];
  logic [15:0] last_dout;
  int unsigned cyc = 0;
  int unsigned vcyc[$];

  tdm_demux_16ch dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus; the model tracks the bits collected in the current frame.
  task automatic beat(input bit v, input bit fs, input bit d);
    bit          e;
    logic [15:0] f;
    @(negedge clk);
    din_valid  = v;
    frame_sync = fs;
    din        = d;
    e = 1'b0;
    if (v) begin
      if (fs) begin
        e = m_locked && (m_bits.size() != 0);
        m_bits.delete();
        m_bits.push_back(d);
        m_locked = 1'b1;
      end else if (m_locked) begin
        if (m_bits.size() == 0) begin
          e        = 1'b1;
          m_locked = 1'b0;
        end else begin
          m_bits.push_back(d);
          if (m_bits.size() == 16) begin
            for (int i = 0; i < 16; i++) f[i] = m_bits[i];
            exp_q.push_back(f);
            m_bits.delete();
          end
        end
      end
    end
    @(posedge clk);
    #1;
    check("slot", 32'(slot), 32'(m_bits.size()));
    check("locked", 32'(locked), 32'(m_locked));
    check("sync_err", 32'(sync_err), 32'(e));
  endtask

  // Sends a frame starting with frame_sync; idle cycles carry random junk on din/frame_sync.
  task automatic send_frame(input logic [15:0] data, input int unsigned idle_pct);
    for (int k = 0; k < 16; k++) begin
      while ($urandom_range(99) < idle_pct)
        beat(1'b0, 1'($urandom), 1'($urandom));
      beat(1'b1, (k == 0), data[k]);
    end
  endtask

  task automatic reset_mid();
    @(negedge clk);
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_slot", 32'(slot), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    m_bits.delete();
    m_locked  = 1'b0;
    exp_q.delete();
    last_dout = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every dout_valid pops one expected frame; otherwise dout must hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid) begin
        vcyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dout_valid: unexpected pulse with dout=%h, required no pulse", dout);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("dout", 32'(dout), 32'(e));
          last_dout = e;
        end
      end else begin
        check("dout_hold", 32'(dout), 32'(last_dout));
      end
    end
  end

  initial begin
    rst        = 1'b1;
    din        = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    m_locked   = 1'b0;
    last_dout  = '0;
    repeat (2) @(negedge clk);
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_dout_valid", 32'(dout_valid), 32'd0);
    check("reset_slot", 32'(slot), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_sync_err", 32'(sync_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    send_frame(16'hA5C3, 0);

    repeat (2) beat(1'b0, 1'b0, 1'b0);
    vcyc.delete();
    send_frame(16'h0001, 0);
    send_frame(16'h8000, 0);
    send_frame(16'hFFFF, 0);
    repeat (2) beat(1'b0, 1'b0, 1'b0);
    check("b2b_pulses", 32'(vcyc.size()), 32'd3);
    if (vcyc.size() == 3) begin
      check("b2b_gap01", vcyc[1] - vcyc[0], 32'd16);
      check("b2b_gap12", vcyc[2] - vcyc[1], 32'd16);
    end

    send_frame(16'h1234, 40);

    beat(1'b1, 1'b1, 1'($urandom));
    repeat (6) beat(1'b1, 1'b0, 1'($urandom));
    send_frame(16'h00FF, 0);

    send_frame(16'($urandom), 0);
    beat(1'b1, 1'b0, 1'b1);
    repeat (5) beat(1'b1, 1'b0, 1'($urandom));
    send_frame(16'hBEEF, 20);

    for (int n = 0; n < 20; n++) send_frame(16'($urandom), 15);
    repeat (400) beat(($urandom_range(3) != 0), ($urandom_range(19) == 0), 1'($urandom));

    beat(1'b1, 1'b1, 1'b1);
    repeat (8) beat(1'b1, 1'b0, 1'($urandom));
    reset_mid();
    send_frame(16'h5A5A, 0);
    repeat (3) beat(1'b0, 1'b0, 1'b0);

    check("frames_pending", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
